// File: rtl/gpu_apb_master.sv
// APB write initiator feeding the GPU command slave from a command FIFO.
// Optional GPU_APB_PREADY_EN adds pReady_i wait states in ACCESS.
module gpu_apb_master #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              cmd_addr_i,
  input  logic [31:0]              cmd_data_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  output logic [31:0]              pAddr_o,
  output logic [31:0]              pDataWrite_o,
  output logic                     pSel_o,
  output logic                     pEnable_o,
  output logic                     pWrite_o,
`ifdef GPU_APB_PREADY_EN
  input  logic                     pReady_i,
`endif
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     idle_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    GAP
  } state_t;

  state_t        state, state_nx;
  logic [31:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [7:0]    gap_cnt, gap_nx;
  logic [31:0]   addr_q, data_q;
  logic          push, pop, done, has_cmd;

  assign cmd_ready_o = (count != CW'(DEPTH));
  assign push        = cmd_valid_i & cmd_ready_o;
  assign has_cmd     = (count != '0);

`ifdef GPU_APB_PREADY_EN
  assign done = pReady_i;
`else
  assign done = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    gap_nx   = gap_cnt;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (has_cmd) begin
          state_nx = SETUP;
          pop      = 1'b1;
        end
      end
      SETUP: state_nx = ACCESS;
      ACCESS: begin
        if (done) begin
          if (GAP_CYCLES > 0) begin
            state_nx = GAP;
            gap_nx   = 8'(GAP_CYCLES);
          end else if (has_cmd) begin
            state_nx = SETUP;
            pop      = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      GAP: begin
        gap_nx = gap_cnt - 8'd1;
        // last settle cycle: hand straight to the next transfer if one waits
        if (gap_cnt <= 8'd1) begin
          if (has_cmd) begin
            state_nx = SETUP;
            pop      = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= cmd_addr_i;
      data_mem[wr_ptr] <= cmd_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state   <= state_nx;
      gap_cnt <= gap_nx;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (pop) begin
        addr_q <= addr_mem[rd_ptr];
        data_q <= data_mem[rd_ptr];
      end else if (state_nx == IDLE || state_nx == GAP) begin
        addr_q <= '0;
        data_q <= '0;
      end
    end
  end

  assign pSel_o       = (state == SETUP) || (state == ACCESS);
  assign pEnable_o    = (state == ACCESS);
  assign pWrite_o     = pSel_o;
  assign pAddr_o      = addr_q;
  assign pDataWrite_o = data_q;
  assign fifo_count_o = count;
  assign idle_o       = (state == IDLE) && !has_cmd;

endmodule

// File: tb/tb_gpu_apb_master.sv
// Bench for gpu_apb_master: transfer-schedule reference model,
// two instances (GAP_CYCLES 0 and 3) sharing one stimulus bus.
module tb_gpu_apb_master;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_valid = 1'b0;
  logic        p_ready = 1'b1;

  logic [31:0] m_addr, m_data, g_addr, g_data;
  logic        m_sel, m_en, m_wr, m_ready, m_idle;
  logic        g_sel, g_en, g_wr, g_ready, g_idle;
  logic [2:0]  m_cnt, g_cnt;

  gpu_apb_master #(.DEPTH(DEPTH), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(m_ready),
    .pAddr_o(m_addr), .pDataWrite_o(m_data),
    .pSel_o(m_sel), .pEnable_o(m_en), .pWrite_o(m_wr),
`ifdef GPU_APB_PREADY_EN
    .pReady_i(p_ready),
`endif
    .fifo_count_o(m_cnt), .idle_o(m_idle)
  );

  gpu_apb_master #(.DEPTH(DEPTH), .GAP_CYCLES(3)) dut_gap (
    .clk(clk), .rst(rst),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(g_ready),
    .pAddr_o(g_addr), .pDataWrite_o(g_data),
    .pSel_o(g_sel), .pEnable_o(g_en), .pWrite_o(g_wr),
`ifdef GPU_APB_PREADY_EN
    .pReady_i(p_ready),
`endif
    .fifo_count_o(g_cnt), .idle_o(g_idle)
  );

  bit          tgt;
  logic [71:0] m_bus, g_bus, obs;
  assign m_bus = {m_sel, m_en, m_wr, m_addr, m_data, m_ready, m_cnt, m_idle};
  assign g_bus = {g_sel, g_en, g_wr, g_addr, g_data, g_ready, g_cnt, g_idle};
  assign obs   = tgt ? g_bus : m_bus;

  int nasserts = 0;
  int nfails   = 0;

  // Each accepted command k: accepted at edge a, SETUP from edge s,
  // completes at edge c = s + 2 + waits; next s = max(a+1, c_prev+gap).
  int          t;
  int          g;
  int          last_c;
  int          a_q[$], s_q[$], c_q[$], w_q[$];
  logic [31:0] ad_q[$], dd_q[$];

  logic        e_sel, e_en, e_ready, e_idle;
  logic [31:0] e_addr, e_data;
  logic [2:0]  e_cnt;
  logic [71:0] e_bus;

  function automatic void model_eval();
    int  cnt = 0;
    bit  in_gap = 0;
    e_sel  = 1'b0;
    e_en   = 1'b0;
    e_addr = '0;
    e_data = '0;
    foreach (a_q[k]) begin
      if (a_q[k] <= t) cnt++;
      if (s_q[k] <= t) cnt--;
      if (s_q[k] <= t && t < c_q[k]) begin
        e_sel  = 1'b1;
        e_en   = (t > s_q[k]);
        e_addr = ad_q[k];
        e_data = dd_q[k];
      end
      if (c_q[k] <= t && t < c_q[k] + g) in_gap = 1;
    end
    e_cnt   = 3'(cnt);
    e_ready = (cnt != DEPTH);
    e_idle  = !e_sel && !in_gap && (cnt == 0);
    e_bus   = {e_sel, e_en, e_sel, e_addr, e_data, e_ready, e_cnt, e_idle};
  endfunction

  task automatic do_reset();
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    a_q.delete(); s_q.delete(); c_q.delete(); w_q.delete();
    ad_q.delete(); dd_q.delete();
    t = 0;
    last_c = -1000;
    model_eval();
  endtask

  task automatic step(input bit v, input logic [31:0] ad,
                      input logic [31:0] dt, input int w, output bit acc);
    int a, s, weff;
    acc = v && e_ready;
    cmd_valid = v;
    cmd_addr  = ad;
    cmd_data  = dt;
`ifdef GPU_APB_PREADY_EN
    weff = w;
`else
    weff = 0;
`endif
    if (acc) begin
      a = t + 1;
      s = (a + 1 > last_c + g) ? a + 1 : last_c + g;
      a_q.push_back(a); s_q.push_back(s);
      c_q.push_back(s + 2 + weff); w_q.push_back(weff);
      ad_q.push_back(ad); dd_q.push_back(dt);
      last_c = s + 2 + weff;
    end
    p_ready = 1'($urandom_range(0, 1));
    foreach (s_q[k])
      if (s_q[k] + 1 <= t && t <= s_q[k] + 1 + w_q[k])
        p_ready = (t == s_q[k] + 1 + w_q[k]);
    @(negedge clk);
    t++;
    model_eval();
  endtask

  task automatic test_reset();
    bit acc, hit;
    tgt = 0; g = 0;
    do_reset();
    nasserts++;
    if (obs !== e_bus) begin
      nfails++;
      $display("FAIL reset_state got %h want %h", obs, e_bus);
    end
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      step(1, $urandom, $urandom, 0, acc);
      nasserts++;
      if (obs !== e_bus) begin
        nfails++;
        $display("FAIL reset_fill t=%0d got %h want %h", t, obs, e_bus);
      end
      if (e_en && e_cnt == 3'd3) hit = 1;
    end
    nasserts++;
    if (!hit) begin
      nfails++;
      $display("FAIL reset_reach got 0 want 1");
    end
    do_reset();
    nasserts++;
    if (obs !== {3'b000, 64'h0, 1'b1, 3'd0, 1'b1}) begin
      nfails++;
      $display("FAIL reset_mid got %h want all-zero/ready/idle", obs);
    end
    for (int i = 0; i < 6; i++) begin
      step(0, '0, '0, 0, acc);
      nasserts++;
      if (obs !== e_bus) begin
        nfails++;
        $display("FAIL reset_quiet t=%0d got %h want %h", t, obs, e_bus);
      end
    end
  endtask

  task automatic test_single();
    bit acc;
    tgt = 0; g = 0;
    do_reset();
    step(1, 32'h0000_0004, 32'h1000_00FF, 0, acc);
    for (int i = 0; i < 6; i++) begin
      nasserts++;
      if (obs !== e_bus) begin
        nfails++;
        $display("FAIL single t=%0d got %h want %h", t, obs, e_bus);
      end
      if (t == 2) begin
        nasserts++;
        if ({m_sel, m_en, m_addr, m_data} !== {2'b10, 32'h4, 32'h1000_00FF}) begin
          nfails++;
          $display("FAIL single_setup got %b%b %h %h want 10 4 100000ff",
                   m_sel, m_en, m_addr, m_data);
        end
      end
      if (t == 4) begin
        nasserts++;
        if ({m_sel, m_idle} !== 2'b01) begin
          nfails++;
          $display("FAIL single_idle got %b%b want 01", m_sel, m_idle);
        end
      end
      step(0, '0, '0, 0, acc);
    end
  endtask

  task automatic test_fill();
    bit acc, saw_full, want_full;
    int sent, sel_cycles;
    logic [31:0] ad, dt;
    tgt = 0; g = 0;
    do_reset();
    sent = 0; sel_cycles = 0; saw_full = 0; want_full = 0;
    ad = $urandom; dt = $urandom;
    for (int i = 0; i < 60; i++) begin
      if (!e_ready) want_full = 1;
      if (!m_ready) saw_full = 1;
      if (m_sel) sel_cycles++;
      step(sent < 9, ad, dt, 0, acc);
      if (acc) begin
        sent++;
        ad = $urandom; dt = $urandom;
      end
      nasserts++;
      if (obs !== e_bus) begin
        nfails++;
        $display("FAIL fill t=%0d got %h want %h", t, obs, e_bus);
      end
    end
    nasserts++;
    if (saw_full !== want_full || !want_full) begin
      nfails++;
      $display("FAIL fill_full got %0d want %0d", saw_full, want_full);
    end
    nasserts++;
    if (sel_cycles != 18) begin
      nfails++;
      $display("FAIL fill_sel_cycles got %0d want 18", sel_cycles);
    end
  endtask

  task automatic test_gap();
    bit acc, seen;
    int gap_len, phase;
    tgt = 1; g = 3;
    do_reset();
    step(1, $urandom, $urandom, 0, acc);
    step(1, $urandom, $urandom, 0, acc);
    gap_len = 0; phase = 0;
    for (int i = 0; i < 16; i++) begin
      nasserts++;
      if (obs !== e_bus) begin
        nfails++;
        $display("FAIL gap t=%0d got %h want %h", t, obs, e_bus);
      end
      seen = g_sel;
      if (phase == 0 && seen) phase = 1;
      else if (phase == 1 && !seen) begin phase = 2; gap_len = 1; end
      else if (phase == 2 && !seen) gap_len++;
      else if (phase == 2 && seen) phase = 3;
      step(0, '0, '0, 0, acc);
    end
    nasserts++;
    if (gap_len != 3 || phase != 3) begin
      nfails++;
      $display("FAIL gap_len got %0d want 3", gap_len);
    end
  endtask

  task automatic test_pready();
    bit acc;
    int en_cycles, want;
`ifdef GPU_APB_PREADY_EN
    want = 6;
`else
    want = 1;
`endif
    tgt = 0; g = 0;
    do_reset();
    step(1, $urandom, $urandom, 5, acc);
    en_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      nasserts++;
      if (obs !== e_bus) begin
        nfails++;
        $display("FAIL pready t=%0d got %h want %h", t, obs, e_bus);
      end
      if (m_en) en_cycles++;
      step(0, '0, '0, 0, acc);
    end
    nasserts++;
    if (en_cycles != want) begin
      nfails++;
      $display("FAIL pready_len got %0d want %0d", en_cycles, want);
    end
  endtask

  task automatic test_random();
    bit acc;
    for (int r = 0; r < 2; r++) begin
      tgt = (r == 1);
      g = (r == 1) ? 3 : 0;
      do_reset();
      for (int i = 0; i < 300; i++) begin
        step(i < 260 && $urandom_range(0, 9) < 6, $urandom, $urandom,
             int'($urandom_range(0, 3)), acc);
        nasserts++;
        if (obs !== e_bus) begin
          nfails++;
          $display("FAIL random g=%0d t=%0d got %h want %h", g, t, obs, e_bus);
        end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_gap();
    test_pready();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nasserts, nfails);
    $finish;
  end

endmodule
